// File: rtl/bsg_ring_occupancy_tracker_pkg.sv
// Shared types and helpers for bsg_ring_occupancy_tracker and its circular pointers.
// Holds the tracker-state snapshot and the modulo-slots add that is used when the slot count is not a power of two.
package bsg_ring_occ_pkg;

    // Wide enough for any practical ring.
    // Each user zero-extends into it.
    localparam int unsigned state_width_gp = 32;

    typedef logic [state_width_gp-1:0] state_word_t;

    typedef struct packed {
        state_word_t wptr;
        state_word_t rptr;
        state_word_t occupancy;
    } tracker_state_t;

    // Computes (ptr + add) mod slots, assuming ptr < slots and add <= slots.
    // Both candidates are formed in parallel, and the sign of the wrapped one picks the result.
    function automatic state_word_t ring_add(input state_word_t ptr,
                                             input state_word_t add,
                                             input state_word_t slots);
        logic [state_width_gp:0] sum_raw;
        logic [state_width_gp:0] sum_wrap;
        sum_raw  = {1'b0, ptr} + {1'b0, add};
        sum_wrap = sum_raw - {1'b0, slots};
        return sum_wrap[state_width_gp] ? state_word_t'(sum_raw) : state_word_t'(sum_wrap);
    endfunction

    function automatic bit is_pow2(input int unsigned value);
        return (value != 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/bsg_ring_occupancy_tracker_if.sv
// Producer/consumer handshake bundle for bsg_ring_occupancy_tracker.
// Signal suffixes are named from the tracker's side.
interface bsg_ring_occupancy_tracker_if #(
    parameter int add_width_p = 3
);

    logic                   enq_v_i;
    logic [add_width_p-1:0] enq_count_i;
    logic                   enq_yumi_o;

    logic                   deq_v_i;
    logic [add_width_p-1:0] deq_count_i;
    logic                   deq_yumi_o;

    // Driven by the producer/consumer side.
    modport master (
        output enq_v_i,
        output enq_count_i,
        output deq_v_i,
        output deq_count_i,
        input  enq_yumi_o,
        input  deq_yumi_o
    );

    // Driven by the tracker.
    modport slave (
        input  enq_v_i,
        input  enq_count_i,
        input  deq_v_i,
        input  deq_count_i,
        output enq_yumi_o,
        output deq_yumi_o
    );

    modport monitor (
        input enq_v_i,
        input enq_count_i,
        input enq_yumi_o,
        input deq_v_i,
        input deq_count_i,
        input deq_yumi_o
    );

endinterface

// File: rtl/bsg_ring_occupancy_tracker_circular_ptr_async.sv
// Circular pointer with asynchronous active-low reset.
// It advances by add_i (0..max_add_p) modulo slots_p and exposes both the current and the next value.
module bsg_circular_ptr_async
    import bsg_ring_occ_pkg::*;
#(
    parameter  int slots_p      = 8,
    parameter  int max_add_p    = 4,
    localparam int ptr_width_lp = (slots_p < 2) ? 1 : $clog2(slots_p),
    localparam int add_width_lp = $clog2(max_add_p + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n_i,
    input  logic [add_width_lp-1:0] add_i,
    output logic [ptr_width_lp-1:0] o,
    output logic [ptr_width_lp-1:0] n_o
);

    if (slots_p < 2) begin : g_bad_slots
        $error("bsg_circular_ptr_async: slots_p must be >= 2");
    end
    if ((max_add_p < 1) || (max_add_p > slots_p)) begin : g_bad_add
        $error("bsg_circular_ptr_async: max_add_p must be in 1..slots_p");
    end

    logic [ptr_width_lp-1:0] ptr_q;
    logic [ptr_width_lp-1:0] ptr_d;

    if (is_pow2(slots_p)) begin : g_pow2
        // With a power-of-two ring, dropping the carry out of the pointer width gives the wrap for free.
        localparam int sum_width_lp = ptr_width_lp + add_width_lp;
        assign ptr_d = ptr_width_lp'(sum_width_lp'(ptr_q) + sum_width_lp'(add_i));
    end else begin : g_wrap
        assign ptr_d = ptr_width_lp'(ring_add(state_word_t'(ptr_q),
                                              state_word_t'(add_i),
                                              state_word_t'(slots_p)));
    end

    // NOTE: non-blocking assignment, so every flop in the design samples pre-edge values no matter how the blocks are ordered.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign o   = ptr_q;
    assign n_o = ptr_d;

endmodule

// File: rtl/bsg_ring_occupancy_tracker.sv
// Occupancy/free bookkeeping and write/read pointer generation for a multi-entry ring buffer.
// The optional macro BSG_RING_OCC_TRACKER_STICKY_ERR_EN turns err_o into a sticky flag that only reset clears.
module bsg_ring_occupancy_tracker
    import bsg_ring_occ_pkg::*;
#(
    parameter  int slots_p      = 8,
    parameter  int max_add_p    = 4,
    localparam int ptr_width_lp = (slots_p < 2) ? 1 : $clog2(slots_p),
    localparam int cnt_width_lp = $clog2(slots_p + 1),
    localparam int add_width_lp = $clog2(max_add_p + 1)
) (
    input  logic                        clk,
    input  logic                        reset_n_i,
    bsg_ring_occupancy_tracker_if.slave hs_if,
    output logic [ptr_width_lp-1:0]     wptr_o,
    output logic [ptr_width_lp-1:0]     rptr_o,
    output logic [ptr_width_lp-1:0]     wptr_n_o,
    output logic [cnt_width_lp-1:0]     occupancy_o,
    output logic [cnt_width_lp-1:0]     free_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic                        err_o
);

    localparam int occ_width_lp = cnt_width_lp + 1;

    if (slots_p < 2) begin : g_bad_slots
        $error("bsg_ring_occupancy_tracker: slots_p must be >= 2");
    end
    if ((max_add_p < 1) || (max_add_p > slots_p)) begin : g_bad_add
        $error("bsg_ring_occupancy_tracker: max_add_p must be in 1..slots_p");
    end

    logic [add_width_lp-1:0] enq_count;
    logic [add_width_lp-1:0] deq_count;
    logic                    enq_ok;
    logic                    deq_ok;
    logic                    err_now;
    logic [add_width_lp-1:0] enq_add;
    logic [add_width_lp-1:0] deq_add;
    logic [occ_width_lp-1:0] occ_wide;
    logic [cnt_width_lp-1:0] occ_q;
    logic [cnt_width_lp-1:0] occ_d;
    logic [cnt_width_lp-1:0] free_q;
    logic [cnt_width_lp-1:0] free_d;
    logic [ptr_width_lp-1:0] rptr_n;

    assign enq_count = add_width_lp'(hs_if.enq_count_i);
    assign deq_count = add_width_lp'(hs_if.deq_count_i);

    // Acceptance looks only at the registered free/occupancy values, so a dequeue never makes room for an enqueue in the same cycle.
    // Gating with reset_n_i keeps yumi and err low while reset is held.
    // NOTE: every always_comb output gets a value on every path; any path that leaves one unassigned would infer a latch.
    always_comb begin
        enq_ok   = 1'b0;
        deq_ok   = 1'b0;
        err_now  = 1'b0;
        enq_add  = '0;
        deq_add  = '0;
        occ_wide = '0;
        occ_d    = '0;
        free_d   = '0;

        enq_ok = reset_n_i & hs_if.enq_v_i & (enq_count != '0)
               & (cnt_width_lp'(enq_count) <= free_q);
        deq_ok = reset_n_i & hs_if.deq_v_i & (deq_count != '0)
               & (cnt_width_lp'(deq_count) <= occ_q);

        err_now = reset_n_i
                & ((hs_if.enq_v_i & ~enq_ok & (enq_count != '0))
                 | (hs_if.deq_v_i & ~deq_ok & (deq_count != '0)));

        enq_add = enq_ok ? enq_count : '0;
        deq_add = deq_ok ? deq_count : '0;

        occ_wide = occ_width_lp'(occ_q) + occ_width_lp'(enq_add) - occ_width_lp'(deq_add);
        occ_d    = cnt_width_lp'(occ_wide);
        free_d   = cnt_width_lp'(slots_p) - occ_d;
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            occ_q  <= '0;
            free_q <= cnt_width_lp'(slots_p);
        end else begin
            occ_q  <= occ_d;
            free_q <= free_d;
        end
    end

    bsg_circular_ptr_async #(
        .slots_p   (slots_p),
        .max_add_p (max_add_p)
    ) wptr_inst (
        .clk       (clk),
        .reset_n_i (reset_n_i),
        .add_i     (enq_add),
        .o         (wptr_o),
        .n_o       (wptr_n_o)
    );

    bsg_circular_ptr_async #(
        .slots_p   (slots_p),
        .max_add_p (max_add_p)
    ) rptr_inst (
        .clk       (clk),
        .reset_n_i (reset_n_i),
        .add_i     (deq_add),
        .o         (rptr_o),
        .n_o       (rptr_n)
    );

`ifdef BSG_RING_OCC_TRACKER_STICKY_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | err_now;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = err_now;
`endif

    assign hs_if.enq_yumi_o = enq_ok;
    assign hs_if.deq_yumi_o = deq_ok;
    assign occupancy_o      = occ_q;
    assign free_o           = free_q;
    assign full_o           = (occ_q == cnt_width_lp'(slots_p));
    assign empty_o          = (occ_q == '0);

    // Both the current and the next state must satisfy wptr == (rptr + occupancy) mod slots_p; a full ring therefore has wptr == rptr.
    tracker_state_t cur_state;
    tracker_state_t next_state;

    always_comb begin
        cur_state            = '0;
        next_state           = '0;
        cur_state.wptr       = state_word_t'(wptr_o);
        cur_state.rptr       = state_word_t'(rptr_o);
        cur_state.occupancy  = state_word_t'(occ_q);
        next_state.wptr      = state_word_t'(wptr_n_o);
        next_state.rptr      = state_word_t'(rptr_n);
        next_state.occupancy = state_word_t'(occ_d);
    end

    a_cur_invariant : assert property (@(posedge clk) disable iff (!reset_n_i)
        cur_state.wptr == ring_add(cur_state.rptr, cur_state.occupancy, state_word_t'(slots_p)));

    a_next_invariant : assert property (@(posedge clk) disable iff (!reset_n_i)
        next_state.wptr == ring_add(next_state.rptr, next_state.occupancy, state_word_t'(slots_p)));

endmodule

// File: tb/tb_bsg_ring_occupancy_tracker.sv
// Bench for bsg_ring_occupancy_tracker using an 8-slot and a 6-slot instance side by side.
// Directed ring scenarios run first, then randomized traffic with asynchronous reset drops, all checked against a queue-free arithmetic model.
`timescale 1ns/1ps
module tb_bsg_ring_occupancy_tracker;

    localparam int max_add_lp = 4;
    localparam int add_w_lp   = $clog2(max_add_lp + 1);

`ifdef BSG_RING_OCC_TRACKER_STICKY_ERR_EN
    localparam bit sticky_lp = 1'b1;
`else
    localparam bit sticky_lp = 1'b0;
`endif

    typedef struct {
        bit ev;
        int ec;
        bit dv;
        int dc;
    } req_t;

    typedef enum int {
        O_WPTR,
        O_RPTR,
        O_WPTR_N,
        O_OCC,
        O_FREE,
        O_FULL,
        O_EMPTY,
        O_ERR,
        O_ENQ_Y,
        O_DEQ_Y
    } obs_e;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    bsg_ring_occupancy_tracker_if #(.add_width_p(add_w_lp)) if_a ();
    bsg_ring_occupancy_tracker_if #(.add_width_p(add_w_lp)) if_b ();

    logic [2:0] wptr_a, rptr_a, wptr_n_a;
    logic [3:0] occ_a, free_a;
    logic       full_a, empty_a, err_a;
    logic [2:0] wptr_b, rptr_b, wptr_n_b;
    logic [2:0] occ_b, free_b;
    logic       full_b, empty_b, err_b;

    bsg_ring_occupancy_tracker #(.slots_p(8), .max_add_p(max_add_lp)) dut_a (
        .clk         (clk),
        .reset_n_i   (reset_n),
        .hs_if       (if_a),
        .wptr_o      (wptr_a),
        .rptr_o      (rptr_a),
        .wptr_n_o    (wptr_n_a),
        .occupancy_o (occ_a),
        .free_o      (free_a),
        .full_o      (full_a),
        .empty_o     (empty_a),
        .err_o       (err_a)
    );

    bsg_ring_occupancy_tracker #(.slots_p(6), .max_add_p(max_add_lp)) dut_b (
        .clk         (clk),
        .reset_n_i   (reset_n),
        .hs_if       (if_b),
        .wptr_o      (wptr_b),
        .rptr_o      (rptr_b),
        .wptr_n_o    (wptr_n_b),
        .occupancy_o (occ_b),
        .free_o      (free_b),
        .full_o      (full_b),
        .empty_o     (empty_b),
        .err_o       (err_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: ring positions and fill level as plain integers.
    int slots_of [2] = '{8, 6};
    int m_w      [2];
    int m_r      [2];
    int m_occ    [2];
    bit m_err    [2];

    function automatic int obs(input int k, input obs_e s);
        if (k == 0) begin
            case (s)
                O_WPTR:   return int'(wptr_a);
                O_RPTR:   return int'(rptr_a);
                O_WPTR_N: return int'(wptr_n_a);
                O_OCC:    return int'(occ_a);
                O_FREE:   return int'(free_a);
                O_FULL:   return int'(full_a);
                O_EMPTY:  return int'(empty_a);
                O_ERR:    return int'(err_a);
                O_ENQ_Y:  return int'(if_a.enq_yumi_o);
                O_DEQ_Y:  return int'(if_a.deq_yumi_o);
                default:  return -1;
            endcase
        end
        case (s)
            O_WPTR:   return int'(wptr_b);
            O_RPTR:   return int'(rptr_b);
            O_WPTR_N: return int'(wptr_n_b);
            O_OCC:    return int'(occ_b);
            O_FREE:   return int'(free_b);
            O_FULL:   return int'(full_b);
            O_EMPTY:  return int'(empty_b);
            O_ERR:    return int'(err_b);
            O_ENQ_Y:  return int'(if_b.enq_yumi_o);
            O_DEQ_Y:  return int'(if_b.deq_yumi_o);
            default:  return -1;
        endcase
    endfunction

    task automatic check(input string tag, input int k, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s[inst %0d] observed %0d expected %0d", tag, k, observed, expected);
        end
    endtask

    function automatic req_t mk(input bit ev, input int ec, input bit dv, input int dc);
        req_t r;
        r.ev = ev;
        r.ec = ec;
        r.dv = dv;
        r.dc = dc;
        return r;
    endfunction

    function automatic req_t rnd_req();
        req_t r;
        r.ev = ($urandom_range(0, 3) != 0);
        r.ec = $urandom_range(0, max_add_lp);
        r.dv = ($urandom_range(0, 3) != 0);
        r.dc = $urandom_range(0, max_add_lp);
        return r;
    endfunction

    task automatic drive(input int k, input req_t r);
        if (k == 0) begin
            if_a.enq_v_i     = r.ev;
            if_a.enq_count_i = add_w_lp'(r.ec);
            if_a.deq_v_i     = r.dv;
            if_a.deq_count_i = add_w_lp'(r.dc);
        end else begin
            if_b.enq_v_i     = r.ev;
            if_b.enq_count_i = add_w_lp'(r.ec);
            if_b.deq_v_i     = r.dv;
            if_b.deq_count_i = add_w_lp'(r.dc);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_w[k]   = 0;
            m_r[k]   = 0;
            m_occ[k] = 0;
            m_err[k] = 1'b0;
        end
    endtask

    task automatic check_state(input int k, input string tag);
        int ow, orp, oo;
        check({tag, ".wptr"},  k, obs(k, O_WPTR),  m_w[k]);
        check({tag, ".rptr"},  k, obs(k, O_RPTR),  m_r[k]);
        check({tag, ".occ"},   k, obs(k, O_OCC),   m_occ[k]);
        check({tag, ".free"},  k, obs(k, O_FREE),  slots_of[k] - m_occ[k]);
        check({tag, ".full"},  k, obs(k, O_FULL),  int'(m_occ[k] == slots_of[k]));
        check({tag, ".empty"}, k, obs(k, O_EMPTY), int'(m_occ[k] == 0));
        ow  = obs(k, O_WPTR);
        orp = obs(k, O_RPTR);
        oo  = obs(k, O_OCC);
        check({tag, ".invariant_wptr"}, k, ow, (orp + oo) % slots_of[k]);
    endtask

    // One clock: starts and ends at a falling edge. Outputs that are combinational are checked before the rising edge, and registered state after it.
    task automatic cycle(input req_t r0, input req_t r1, input string tag);
        req_t rq [2];
        bit   ey [2];
        bit   dy [2];
        bit   er [2];
        rq[0] = r0;
        rq[1] = r1;
        drive(0, r0);
        drive(1, r1);
        #1;
        for (int k = 0; k < 2; k++) begin
            ey[k] = rq[k].ev && (rq[k].ec != 0) && (rq[k].ec <= slots_of[k] - m_occ[k]);
            dy[k] = rq[k].dv && (rq[k].dc != 0) && (rq[k].dc <= m_occ[k]);
            er[k] = (rq[k].ev && !ey[k] && (rq[k].ec != 0)) ||
                    (rq[k].dv && !dy[k] && (rq[k].dc != 0));
            check({tag, ".enq_yumi"}, k, obs(k, O_ENQ_Y), int'(ey[k]));
            check({tag, ".deq_yumi"}, k, obs(k, O_DEQ_Y), int'(dy[k]));
            check({tag, ".err"},      k, obs(k, O_ERR),   sticky_lp ? int'(m_err[k]) : int'(er[k]));
            check({tag, ".wptr_n"},   k, obs(k, O_WPTR_N),
                  (m_w[k] + (ey[k] ? rq[k].ec : 0)) % slots_of[k]);
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (ey[k]) begin
                m_w[k]   = (m_w[k] + rq[k].ec) % slots_of[k];
                m_occ[k] = m_occ[k] + rq[k].ec;
            end
            if (dy[k]) begin
                m_r[k]   = (m_r[k] + rq[k].dc) % slots_of[k];
                m_occ[k] = m_occ[k] - rq[k].dc;
            end
            m_err[k] = m_err[k] | er[k];
        end
        #1;
        for (int k = 0; k < 2; k++) check_state(k, tag);
        @(negedge clk);
    endtask

    // Drops reset partway through a low clock phase while traffic is live; everything must clear before the next clock edge.
    task automatic async_reset_mid(input string tag);
        drive(0, rnd_req());
        drive(1, rnd_req());
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            check_state(k, tag);
            check({tag, ".enq_yumi"}, k, obs(k, O_ENQ_Y), 0);
            check({tag, ".deq_yumi"}, k, obs(k, O_DEQ_Y), 0);
            check({tag, ".err"},      k, obs(k, O_ERR),   0);
            check({tag, ".wptr_n"},   k, obs(k, O_WPTR_N), 0);
        end
        @(negedge clk);
        drive(0, mk(0, 0, 0, 0));
        drive(1, mk(0, 0, 0, 0));
        #2;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        req_t idle;
        idle = mk(0, 0, 0, 0);
        model_reset();

        // While reset is held, requests must not be accepted or flagged.
        drive(0, mk(1, 1, 1, 1));
        drive(1, mk(1, 1, 1, 1));
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("in_reset", k, obs(k, O_ENQ_Y) + obs(k, O_DEQ_Y) + obs(k, O_ERR), 0);
            check_state(k, "in_reset");
        end
        drive(0, idle);
        drive(1, idle);
        #2;
        reset_n = 1'b1;
        @(negedge clk);

        cycle(idle, idle, "reset_idle");
        check("reset_free_lit", 0, obs(0, O_FREE), 8);
        check("reset_empty_lit", 0, obs(0, O_EMPTY), 1);
        cycle(mk(1, 0, 1, 0), mk(1, 0, 0, 0), "zero_count_noop");

        cycle(idle, mk(1, 4, 0, 0), "b_enq4");
        cycle(mk(1, 4, 0, 0), mk(1, 2, 0, 0), "a_enq4_b_enq2_wrap");
        check("b_wrap_wptr_lit", 1, obs(1, O_WPTR), 0);
        check("b_full_lit", 1, obs(1, O_FULL), 1);
        cycle(idle, mk(1, 1, 0, 0), "b_enq_when_full");
        cycle(mk(1, 4, 1, 4), mk(0, 0, 1, 3), "a_enq4_deq4_b_deq3");
        check("a_same_occ_lit", 0, obs(0, O_OCC), 4);
        check("a_rptr_lit", 0, obs(0, O_RPTR), 4);
        cycle(mk(1, 4, 0, 0), mk(1, 2, 0, 0), "a_fill_b_enq2");
        cycle(mk(1, 1, 1, 1), mk(0, 0, 1, 4), "a_no_bypass_b_deq4_wrap");
        check("b_rptr_wrap_lit", 1, obs(1, O_RPTR), 1);
        check("b_occ_lit", 1, obs(1, O_OCC), 1);
        cycle(mk(1, 1, 0, 0), mk(0, 0, 1, 2), "a_refill_b_deq_too_many");
        check("a_full_again_lit", 0, obs(0, O_FULL), 1);

        for (int i = 0; i < 300; i++) begin
            if (i == 97 || i == 211) async_reset_mid("async_reset");
            cycle(rnd_req(), rnd_req(), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
